// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: stored RX entry layout and FCR trigger levels.
package uart_pkg;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_lvl_t;

  function automatic int unsigned trig_threshold(trig_lvl_t lvl);
    case (lvl)
      TRIG_1:  return 1;
      TRIG_4:  return 4;
      TRIG_8:  return 8;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter: counts baud ticks while idle, saturates at LIMIT.
module uart_rx_timeout #(
  parameter int LIMIT = 640
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear)
      cnt_next = '0;
    else if (tick && (cnt_reg != CW'(LIMIT)))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign expired = (cnt_reg == CW'(LIMIT));

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550 receive FIFO: FWFT character store with error tracking, trigger level,
// overrun and character-timeout indications for the register/interrupt logic.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_PULSES = 640
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       baud_pulse,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pe_in,
  input  logic                       fe_in,
  input  logic                       bi_in,
  input  logic                       pop,
  input  logic                       lsr_rd,
  input  logic                       fifo_en,
  input  logic                       clr,
  input  logic [1:0]                 trig_lvl,
  output logic [DATA_W-1:0]          dout,
  output logic                       pe_out,
  output logic                       fe_out,
  output logic                       bi_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun,
  output logic                       err_in_fifo,
  output logic                       trig,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rx_entry_t         mem [DEPTH];
  rx_entry_t         head;
  rx_entry_t         wr_entry;

  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [CW-1:0]     err_cnt_reg, err_cnt_next;
  logic              overrun_reg;
  logic              fifo_en_reg;

  logic [CW-1:0]     eff_depth;
  logic [CW-1:0]     threshold;
  logic              flush;
  logic              do_pop;
  logic              do_push;
  logic              wr_en;
  logic              ovr_set;
  logic              head_err;
  logic              wr_err;
  logic              to_clear;
  logic              to_expired;

  assign eff_depth = fifo_en ? CW'(DEPTH) : CW'(1);
  assign threshold = fifo_en ? CW'(trig_threshold(trig_lvl_t'(trig_lvl))) : CW'(1);

  assign empty = (count_reg == '0);
  assign full  = (count_reg == eff_depth);

  // Toggling FCR[0] discards stored data exactly like an explicit RX flush.
  assign flush   = clr | (fifo_en ^ fifo_en_reg);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_en   = do_push & ~flush;
  assign ovr_set = push & full & ~do_pop & ~flush;

  always_comb begin
    wr_entry      = '0;
    wr_entry.bi   = bi_in;
    wr_entry.fe   = fe_in;
    wr_entry.pe   = pe_in;
    wr_entry.data = 8'(din);
  end

  assign head     = mem[rd_ptr_reg];
  assign head_err = head.bi | head.fe | head.pe;
  assign wr_err   = bi_in | fe_in | pe_in;

  always_comb begin
    count_next   = count_reg;
    err_cnt_next = err_cnt_reg;
    if (flush) begin
      count_next   = '0;
      err_cnt_next = '0;
    end else begin
      count_next   = count_reg + CW'(wr_en) - CW'(do_pop);
      err_cnt_next = err_cnt_reg + CW'(wr_en & wr_err) - CW'(do_pop & head_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_cnt_reg <= '0;
      overrun_reg <= 1'b0;
      fifo_en_reg <= fifo_en;
    end else begin
      fifo_en_reg <= fifo_en;
      count_reg   <= count_next;
      err_cnt_reg <= err_cnt_next;
      if (ovr_set)
        overrun_reg <= 1'b1;
      else if (lsr_rd)
        overrun_reg <= 1'b0;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_en)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign to_clear = push | pop | flush | empty | ~fifo_en;

  uart_rx_timeout #(
    .LIMIT (TIMEOUT_PULSES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear),
    .tick    (baud_pulse),
    .expired (to_expired)
  );

  assign dout        = empty ? '0 : DATA_W'(head.data);
  assign pe_out      = ~empty & head.pe;
  assign fe_out      = ~empty & head.fe;
  assign bi_out      = ~empty & head.bi;
  assign count       = count_reg;
  assign overrun     = overrun_reg;
  assign err_in_fifo = (err_cnt_reg != '0);
  assign trig        = (count_reg >= threshold);
  assign timeout     = ~empty & fifo_en & to_expired;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for single-cycle behaviour plus
// hand sequences for fill/overrun, wrap, timeout, flush and 16450 mode.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse, push, pop, lsr_rd, fifo_en, clr;
  logic       pe_in, fe_in, bi_in;
  logic [7:0] din;
  logic [1:0] trig_lvl;
  logic [7:0] dout;
  logic       pe_out, fe_out, bi_out, empty, full, overrun, err_in_fifo, trig, timeout;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .DATA_W(8), .TIMEOUT_PULSES(640)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push(push), .din(din),
    .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .pop(pop), .lsr_rd(lsr_rd),
    .fifo_en(fifo_en), .clr(clr), .trig_lvl(trig_lvl), .dout(dout),
    .pe_out(pe_out), .fe_out(fe_out), .bi_out(bi_out), .empty(empty),
    .full(full), .count(count), .overrun(overrun), .err_in_fifo(err_in_fifo),
    .trig(trig), .timeout(timeout)
  );

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       pe;
    logic       pop;
    logic [1:0] tl;
    logic [7:0] e_dout;
    logic       e_empty;
    logic [4:0] e_count;
    logic       e_trig;
    logic       e_err;
    logic       e_pe;
    logic       e_ovr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply the currently driven inputs for one clock, then drop all strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; lsr_rd = 1'b0; clr = 1'b0; baud_pulse = 1'b0;
    pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1; din = d;
    tick();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; fifo_en = 1'b1; trig_lvl = 2'b00; din = 8'h00;
    push = 1'b0; pop = 1'b0; lsr_rd = 1'b0; clr = 1'b0; baud_pulse = 1'b0;
    pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
    tick();
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_flags", {full, overrun, err_in_fifo, trig, timeout, pe_out, fe_out, bi_out}, 0);
    rst = 1'b0;
    tick();

    //           push din   pe pop tl     dout  emp cnt trg err pe ovr
    vecs[0]  = '{0, 8'h00, 0, 0, 2'b00, 8'h00, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 8'h45, 0, 0, 2'b00, 8'h45, 0, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 1, 2'b00, 8'h00, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 1, 2'b00, 8'h00, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 8'h11, 1, 0, 2'b00, 8'h11, 0, 1, 1, 1, 1, 0};
    vecs[5]  = '{1, 8'h22, 0, 0, 2'b00, 8'h11, 0, 2, 1, 1, 1, 0};
    vecs[6]  = '{0, 8'h00, 0, 1, 2'b00, 8'h22, 0, 1, 1, 0, 0, 0};
    vecs[7]  = '{1, 8'h33, 0, 1, 2'b00, 8'h33, 0, 1, 1, 0, 0, 0};
    vecs[8]  = '{0, 8'h00, 0, 1, 2'b00, 8'h00, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 8'h77, 0, 1, 2'b00, 8'h77, 0, 1, 1, 0, 0, 0};
    vecs[10] = '{0, 8'h00, 0, 0, 2'b01, 8'h77, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{0, 8'h00, 0, 1, 2'b01, 8'h00, 1, 0, 0, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      push = vecs[i].push; din = vecs[i].din; pe_in = vecs[i].pe;
      pop = vecs[i].pop; trig_lvl = vecs[i].tl;
      tick();
      chk($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_trig", i), trig, vecs[i].e_trig);
      chk($sformatf("v%0d_err", i), err_in_fifo, vecs[i].e_err);
      chk($sformatf("v%0d_pe", i), pe_out, vecs[i].e_pe);
      chk($sformatf("v%0d_ovr", i), overrun, vecs[i].e_ovr);
      $display("vec %0d: dout=%02h empty=%0d count=%0d trig=%0d err=%0d", i, dout, empty, count, trig, err_in_fifo);
    end

    // Fill to 16 with trigger level 14, then overrun
    trig_lvl = 2'b11;
    for (int i = 0; i < 16; i++) begin
      do_push(8'(i));
      chk($sformatf("fill_count%0d", i), count, i + 1);
      chk($sformatf("fill_trig%0d", i), trig, (i + 1) >= 14);
      chk($sformatf("fill_full%0d", i), full, (i + 1) == 16);
    end
    do_push(8'hAA);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_dout%0d", i), dout, i);
      do_pop();
    end
    chk("drain_empty", empty, 1);
    chk("ovr_sticky", overrun, 1);
    lsr_rd = 1'b1; tick();
    chk("ovr_clear", overrun, 0);
    $display("fill/overrun sequence done");

    // Wrapped pointers, push+pop while full
    for (int i = 0; i < 16; i++) do_push(8'(8'h80 + i));
    chk("wrap_full", full, 1);
    push = 1'b1; pop = 1'b1; din = 8'h5A; tick();
    chk("wrap_pp_count", count, 16);
    chk("wrap_pp_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap_dout%0d", i), dout, (i < 15) ? (8'h81 + i) : 8'h5A);
      do_pop();
    end
    chk("wrap_empty", empty, 1);
    $display("wrap sequence done");

    // Character timeout
    do_push(8'h99);
    for (int i = 0; i < 639; i++) begin
      baud_pulse = 1'b1; tick();
    end
    chk("to_639", timeout, 0);
    baud_pulse = 1'b1; tick();
    chk("to_640", timeout, 1);
    do_pop();
    chk("to_pop", timeout, 0);
    chk("to_pop_empty", empty, 1);
    for (int i = 0; i < 700; i++) begin
      baud_pulse = 1'b1; tick();
    end
    chk("to_idle_empty", timeout, 0);
    $display("timeout sequence done");

    // Flush with overrun set; same-cycle push lost
    for (int i = 0; i < 17; i++) do_push(8'(i));
    for (int i = 0; i < 11; i++) do_pop();
    chk("fl_pre_count", count, 5);
    chk("fl_pre_ovr", overrun, 1);
    clr = 1'b1; push = 1'b1; din = 8'hEE; tick();
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_ovr", overrun, 1);
    chk("fl_dout", dout, 0);
    lsr_rd = 1'b1; tick();
    chk("fl_ovr_clr", overrun, 0);
    $display("flush sequence done");

    // 16450 mode: depth 1, threshold 1, no timeout
    fifo_en = 1'b0; tick();
    chk("m_count0", count, 0);
    do_push(8'h31);
    chk("m_count1", count, 1);
    chk("m_full", full, 1);
    chk("m_trig", trig, 1);
    chk("m_dout", dout, 8'h31);
    do_push(8'h32);
    chk("m_ovr", overrun, 1);
    chk("m_count_hold", count, 1);
    chk("m_dout_hold", dout, 8'h31);
    for (int i = 0; i < 700; i++) begin
      baud_pulse = 1'b1; tick();
    end
    chk("m_no_timeout", timeout, 0);
    do_pop();
    chk("m_pop_empty", empty, 1);
    lsr_rd = 1'b1; tick();
    chk("m_ovr_clr", overrun, 0);
    do_push(8'h41);
    push = 1'b1; din = 8'h42; lsr_rd = 1'b1; tick();
    chk("m_ovr_set_wins", overrun, 1);
    chk("m_dout_41", dout, 8'h41);
    $display("16450 mode sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive FIFO stage of the 16550-compatible UART, directly downstream of the receiver.
- Captures each received character, with its parity/framing/break flags, on the receiver's one-cycle push strobe.
- Presents the oldest entry to the register-read logic (RBR/LSR) in first-word-fall-through form.
- Generates the trigger-level and character-timeout indications used by the interrupt logic, plus LSR overrun (OE, bit 1) and error-in-FIFO (bit 7).

Parameters:
- DEPTH, 16, number of entries; power of two.
- DATA_W, 8, character width; narrower characters arrive zero-extended.
- TIMEOUT_PULSES, 640, baud_pulse ticks with no push/pop before timeout asserts (4 chars x 10 bits x 16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- baud_pulse  in  1  16x oversample tick, one clk wide
- push  in  1  write strobe from receiver, one clk wide
- din  in  DATA_W  received character
- pe_in  in  1  parity error of din
- fe_in  in  1  framing error of din
- bi_in  in  1  break indicator of din
- pop  in  1  RBR read strobe, one clk wide
- lsr_rd  in  1  LSR read strobe; clears overrun
- fifo_en  in  1  FCR[0]; 0 = 16450 single-holding-register mode
- clr  in  1  FCR[1] self-clearing RX flush, one clk wide
- trig_lvl  in  2  FCR[7:6]: 00=1, 01=4, 10=8, 11=14
- dout  out  DATA_W  head-entry character
- pe_out  out  1  head-entry parity error
- fe_out  out  1  head-entry framing error
- bi_out  out  1  head-entry break indicator
- empty  out  1  no entries (LSR[0] = ~empty)
- full  out  1  count == effective depth
- count  out  $clog2(DEPTH)+1  occupancy
- overrun  out  1  LSR[1], sticky
- err_in_fifo  out  1  LSR[7]: some stored entry has pe|fe|bi
- trig  out  1  count >= trigger threshold
- timeout  out  1  character-timeout condition

Behaviour:
- Reset: one clock, clk. Reset is synchronous and active-high on rst. All outputs are 0 on reset except empty = 1. Pointers, count, error counter and timeout counter are cleared.
- Effective depth: DEPTH when fifo_en = 1, else 1. The trigger threshold is 1 when fifo_en = 0.
- Storage: entry = {bi, fe, pe, data}. dout and the head flags are read combinationally at rd_ptr (FWFT). Outputs are 0 when empty.
- Push, not full: write at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1. Visible on dout the cycle after push if the FIFO was empty.
- Push while full, no pop: entry dropped, FIFO unchanged, overrun <= 1.
- Push and pop in the same cycle:
  - Non-empty: both occur, count unchanged, no overrun even if full.
  - Empty: push only.
- Pop while empty: ignored, no state change.
- overrun: set as above, cleared on lsr_rd. A set in the same cycle as lsr_rd wins. Unaffected by clr or fifo_en changes.
- err_in_fifo: maintained as a count of stored entries with pe|fe|bi.
  - Increments on an accepted push with any error flag.
  - Decrements on a pop of an error entry.
  - err_in_fifo = (err count != 0).
- trig: combinational compare of count against the threshold.
- Timeout counter:
  - Reset to 0 on push, pop, clr, or when empty.
  - Otherwise increments on each baud_pulse, saturating at TIMEOUT_PULSES.
  - timeout = ~empty & (counter == TIMEOUT_PULSES). Drops the cycle after a pop or push.
  - Disabled (held 0) when fifo_en = 0.
- Flush: clr, or any change of fifo_en (detected against a registered copy), flushes pointers, count, err count and timeout counter next cycle.
  - Flush has priority over a same-cycle push/pop; that push is lost without setting overrun.
- Priority: rst > flush > push/pop > timeout counting.

Decomposition:
- uart_pkg holds:
  - typedef struct packed rx_entry_t {bi, fe, pe, data[7:0]}
  - enum trig_lvl_t {TRIG_1, TRIG_4, TRIG_8, TRIG_14}
  - function trig_threshold(trig_lvl_t) returning 1/4/8/14
- One sub-module: uart_rx_timeout, the baud_pulse counter with clear/enable/saturate.

Test Plan:
- Reset then fifo_en = 1: push 0x45 (no errors).
  - Next cycle: dout = 0x45, empty = 0, count = 1, trig = 1 with trig_lvl = 00.
  - pop: empty = 1, dout = 0x00.
- trig_lvl = 11: push 0x00..0x0F. trig rises exactly at count = 14, full = 1 at 16.
  - 17th push 0xAA: overrun = 1, count stays 16, pops return 0x00..0x0F in order.
  - lsr_rd: overrun = 0.
- Wrap-around and full-boundary push+pop:
  - Fill 16 entries, then push 0x5A with simultaneous pop: count = 16, overrun = 0.
  - Subsequent pops end with 0x5A.
- Error tracking: push 0x11 (pe_in = 1), then 0x22 (clean).
  - err_in_fifo = 1, pe_out = 1 at head.
  - Pop: err_in_fifo = 0, pe_out = 0, dout = 0x22.
- Timeout: push 1 char, then idle 640 baud_pulses.
  - timeout asserts after pulse 640, not at 639.
  - pop: timeout = 0, empty = 1. An idle empty FIFO never asserts timeout.
- Flush and mode change:
  - 5 entries plus overrun set, pulse clr: count = 0, empty = 1, overrun still 1.
  - fifo_en -> 0: second push without pop sets overrun, and depth 1 is enforced.
